// File: rtl/pdu_gen_pkg.sv
// Shared types for the PDU generator: packet/PDU metadata structs, action codes,
// FSM state encoding and the PDU byte-size helper.
package pdu_gen_pkg;

  localparam int PDUID_WIDTH  = 8;
  localparam int ACTION_WIDTH = 2;

  localparam logic [ACTION_WIDTH-1:0] ACTION_NOCHECK = 2'd0;
  localparam logic [ACTION_WIDTH-1:0] ACTION_CHECK   = 2'd1;

  typedef struct packed {
    logic [ACTION_WIDTH-1:0] action;
  } pkt_meta_t;

  typedef struct packed {
    logic [PDUID_WIDTH-1:0]  pdu_id;
    logic [ACTION_WIDTH-1:0] action;
    logic [4:0]              flits;
    logic [10:0]             pdu_size;
  } pdu_metadata_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ID,
    ST_XFER,
    ST_DROP,
    ST_META
  } state_e;

  // 64 bytes per flit, minus the unused bytes of the final flit.
  function automatic logic [10:0] pdu_bytes(input logic [4:0] flits, input logic [5:0] empty);
    return {flits, 6'b0} - {5'b0, empty};
  endfunction

endpackage

// File: rtl/pdu_gen.sv
// Packet-to-PDU generator: allocates a PDU id, passes the packet through (truncating
// at MAX_FLITS) and then emits PDU metadata. Optional counters under PDU_GEN_STATS_EN.
//
// state  | meaning
// IDLE   | wait for packet metadata while downstream is not almost full
// GET_ID | pop a free PDU id from the emptylist (CHECK packets only)
// XFER   | zero-latency pass-through of packet beats
// DROP   | discard the tail of a truncated packet through its eop
// META   | present PDU metadata until accepted, then release packet metadata
module pdu_gen
  import pdu_gen_pkg::*;
#(
  parameter int MAX_FLITS = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pkt_meta_t              in_meta_data,
  input  logic                   in_meta_valid,
  output logic                   in_meta_ready,
  input  logic [511:0]           in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [5:0]             in_empty,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PDUID_WIDTH-1:0] pdu_emptylist_out_data,
  input  logic                   pdu_emptylist_out_valid,
  output logic                   pdu_emptylist_out_ready,
  output pdu_metadata_t          pdumeta_gen_data,
  output logic                   pdumeta_gen_valid,
  input  logic                   pdumeta_gen_ready,
  output logic [511:0]           pdu_gen_data,
  output logic                   pdu_gen_sop,
  output logic                   pdu_gen_eop,
  output logic [5:0]             pdu_gen_empty,
  output logic                   pdu_gen_valid,
  input  logic                   pdu_gen_ready,
  input  logic                   pdu_gen_almost_full
`ifdef PDU_GEN_STATS_EN
  ,
  output logic [31:0]            stat_pdu_cnt,
  output logic [31:0]            stat_trunc_cnt,
  output logic [31:0]            stat_id_stall_cnt
`endif
);

  localparam logic [4:0] LAST_IDX = 5'(MAX_FLITS - 1);
  localparam logic [4:0] MAX_F5   = 5'(MAX_FLITS);

  state_e                  state, state_nxt;
  logic [4:0]              cnt;
  logic [4:0]              flits_now;
  logic [PDUID_WIDTH-1:0]  pdu_id;
  logic [ACTION_WIDTH-1:0] action;
  pdu_metadata_t           meta_q;
  logic                    meta_valid;

  logic start, is_check;
  logic in_ready_c, out_valid_c, el_ready_c, meta_ready_c;
  logic beat_acc, trunc;
  logic out_eop_c;
  logic [5:0] out_empty_c;

  assign start     = in_meta_valid & ~pdu_gen_almost_full;
  assign is_check  = (in_meta_data.action == ACTION_CHECK);
  assign flits_now = cnt + 5'd1;

  always_comb begin
    state_nxt    = state;
    in_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    el_ready_c   = 1'b0;
    meta_ready_c = 1'b0;
    beat_acc     = 1'b0;
    trunc        = 1'b0;
    out_eop_c    = in_eop;
    out_empty_c  = in_empty;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = is_check ? ST_GET_ID : ST_XFER;
      end
      ST_GET_ID: begin
        el_ready_c = 1'b1;
        if (pdu_emptylist_out_valid) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        in_ready_c  = pdu_gen_ready;
        out_valid_c = in_valid;
        beat_acc    = in_valid & pdu_gen_ready;
        // Last allowed flit without eop: close the PDU here and drop the rest.
        trunc       = (cnt == LAST_IDX) & ~in_eop;
        if (trunc) begin
          out_eop_c   = 1'b1;
          out_empty_c = 6'd0;
        end
        if (beat_acc) begin
          if (in_eop)     state_nxt = ST_META;
          else if (trunc) state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        in_ready_c = 1'b1;
        if (in_valid && in_eop) state_nxt = ST_META;
      end
      ST_META: begin
        meta_ready_c = pdumeta_gen_ready;
        if (pdumeta_gen_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pdu_id     <= '0;
      action     <= ACTION_NOCHECK;
      meta_q     <= '0;
      meta_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      meta_valid <= (state_nxt == ST_META);
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            pdu_id <= '0;
            action <= is_check ? ACTION_CHECK : ACTION_NOCHECK;
          end
        end
        ST_GET_ID: begin
          if (pdu_emptylist_out_valid) pdu_id <= pdu_emptylist_out_data;
        end
        ST_XFER: begin
          if (beat_acc) begin
            cnt <= flits_now;
            if (in_eop) begin
              meta_q <= '{pdu_id: pdu_id, action: action, flits: flits_now,
                          pdu_size: pdu_bytes(flits_now, in_empty)};
            end else if (trunc) begin
              meta_q <= '{pdu_id: pdu_id, action: action, flits: MAX_F5,
                          pdu_size: pdu_bytes(MAX_F5, 6'd0)};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_meta_ready           = meta_ready_c & ~rst;
  assign in_ready                = in_ready_c & ~rst;
  assign pdu_emptylist_out_ready = el_ready_c & ~rst;
  assign pdumeta_gen_valid       = meta_valid & ~rst;
  assign pdumeta_gen_data        = meta_q;
  assign pdu_gen_valid           = out_valid_c & ~rst;
  assign pdu_gen_data            = in_data;
  assign pdu_gen_sop             = in_sop;
  assign pdu_gen_eop             = out_eop_c;
  assign pdu_gen_empty           = out_empty_c;

`ifdef PDU_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pdu_cnt      <= '0;
      stat_trunc_cnt    <= '0;
      stat_id_stall_cnt <= '0;
    end else begin
      if (pdumeta_gen_valid && pdumeta_gen_ready) stat_pdu_cnt <= stat_pdu_cnt + 32'd1;
      if (beat_acc && trunc) stat_trunc_cnt <= stat_trunc_cnt + 32'd1;
      if (state == ST_GET_ID && !pdu_emptylist_out_valid)
        stat_id_stall_cnt <= stat_id_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pdu_gen.sv
// Self-checking bench for pdu_gen: packet-level model of expected PDU beats and
// metadata, a per-cycle compare process, and directed scenarios.
`timescale 1ns/1ps
module tb_pdu_gen;
  import pdu_gen_pkg::*;

  localparam int MAXF = 31;

  logic                   clk = 1'b0;
  logic                   rst;
  pkt_meta_t              in_meta_data;
  logic                   in_meta_valid, in_meta_ready;
  logic [511:0]           in_data;
  logic                   in_sop, in_eop, in_valid, in_ready;
  logic [5:0]             in_empty;
  logic [PDUID_WIDTH-1:0] el_data;
  logic                   el_valid, el_ready;
  pdu_metadata_t          pdumeta_gen_data;
  logic                   pdumeta_gen_valid;
  logic                   mready;
  logic [511:0]           pdu_gen_data;
  logic                   pdu_gen_sop, pdu_gen_eop, pdu_gen_valid;
  logic [5:0]             pdu_gen_empty;
  logic                   pdu_gen_ready = 1'b1;
  logic                   af;
  logic                   bp_en = 1'b0;
`ifdef PDU_GEN_STATS_EN
  logic [31:0] stat_pdu_cnt, stat_trunc_cnt, stat_id_stall_cnt;
`endif

  pdu_gen #(.MAX_FLITS(MAXF)) dut (
    .clk(clk), .rst(rst),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .in_valid(in_valid), .in_ready(in_ready),
    .pdu_emptylist_out_data(el_data), .pdu_emptylist_out_valid(el_valid),
    .pdu_emptylist_out_ready(el_ready),
    .pdumeta_gen_data(pdumeta_gen_data), .pdumeta_gen_valid(pdumeta_gen_valid),
    .pdumeta_gen_ready(mready),
    .pdu_gen_data(pdu_gen_data), .pdu_gen_sop(pdu_gen_sop), .pdu_gen_eop(pdu_gen_eop),
    .pdu_gen_empty(pdu_gen_empty), .pdu_gen_valid(pdu_gen_valid),
    .pdu_gen_ready(pdu_gen_ready), .pdu_gen_almost_full(af)
`ifdef PDU_GEN_STATS_EN
    , .stat_pdu_cnt(stat_pdu_cnt), .stat_trunc_cnt(stat_trunc_cnt),
    .stat_id_stall_cnt(stat_id_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    pdu_gen_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;

  beat_t         exp_beats[$];
  pdu_metadata_t exp_meta[$];
  pdu_metadata_t last_meta;
  beat_t         e_b;
  pdu_metadata_t e_m;
  int checks = 0, errors = 0;
  int out_beats = 0, pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [15:0] tag, input int i);
    logic [31:0] w;
    w = {tag, 16'(i)};
    return {16{w}};
  endfunction

  // Per-cycle comparison of everything the DUT hands downstream.
  logic          prev_mhold = 1'b0;
  pdu_metadata_t prev_mdata;
  always @(negedge clk) begin
    if (rst) begin
      prev_mhold = 1'b0;
    end else begin
      if (prev_mhold) begin
        chk("meta_hold_valid", 64'(pdumeta_gen_valid), 64'd1);
        chk("meta_hold_data", 64'(pdumeta_gen_data), 64'(prev_mdata));
      end
      prev_mhold = pdumeta_gen_valid && !mready;
      prev_mdata = pdumeta_gen_data;
      if (el_ready && el_valid) pops++;
      if (in_meta_ready) chk("meta_ready_with_handshake", 64'(pdumeta_gen_valid & mready), 64'd1);
      if (pdu_gen_valid && pdu_gen_ready) begin
        out_beats++;
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got sop=%0b eop=%0b required no beat", pdu_gen_sop, pdu_gen_eop);
        end else begin
          e_b = exp_beats.pop_front();
          if (pdu_gen_data !== e_b.data || pdu_gen_sop !== e_b.sop ||
              pdu_gen_eop !== e_b.eop || pdu_gen_empty !== e_b.empty) begin
            errors++;
            $display("FAIL beat: got data[31:0]=%h sop=%0b eop=%0b empty=%0d expected data[31:0]=%h sop=%0b eop=%0b empty=%0d",
                     pdu_gen_data[31:0], pdu_gen_sop, pdu_gen_eop, pdu_gen_empty,
                     e_b.data[31:0], e_b.sop, e_b.eop, e_b.empty);
          end
        end
      end
      if (pdumeta_gen_valid && mready) begin
        last_meta = pdumeta_gen_data;
        checks++;
        if (exp_meta.size() == 0) begin
          errors++;
          $display("FAIL unexpected_meta: got %h required none", pdumeta_gen_data);
        end else begin
          e_m = exp_meta.pop_front();
          if (pdumeta_gen_data !== e_m) begin
            errors++;
            $display("FAIL meta: got id=%0d act=%0d flits=%0d size=%0d expected id=%0d act=%0d flits=%0d size=%0d",
                     pdumeta_gen_data.pdu_id, pdumeta_gen_data.action, pdumeta_gen_data.flits,
                     pdumeta_gen_data.pdu_size, e_m.pdu_id, e_m.action, e_m.flits, e_m.pdu_size);
          end
        end
      end
    end
  end

  task automatic drive_beat(input logic [15:0] tag, input int i, input int nb, input logic [5:0] empty);
    int n;
    in_valid = 1'b1;
    in_data  = mk_data(tag, i);
    in_sop   = (i == 0);
    in_eop   = (i == nb - 1);
    in_empty = (i == nb - 1) ? empty : 6'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 400);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got no in_ready required acceptance of beat %0d", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic check, input int nb, input logic [5:0] empty,
                          input logic [PDUID_WIDTH-1:0] id, input logic [15:0] tag);
    int n_out, n;
    beat_t b;
    pdu_metadata_t m;
    n_out = (nb > MAXF) ? MAXF : nb;
    for (int i = 0; i < n_out; i++) begin
      b.data  = mk_data(tag, i);
      b.sop   = (i == 0);
      b.eop   = (i == n_out - 1);
      b.empty = (i == nb - 1) ? empty : 6'd0;
      exp_beats.push_back(b);
    end
    m.pdu_id   = check ? id : '0;
    m.action   = check ? ACTION_CHECK : ACTION_NOCHECK;
    m.flits    = 5'(n_out);
    m.pdu_size = (nb > MAXF) ? 11'(64 * MAXF) : 11'(64 * nb - int'(empty));
    exp_meta.push_back(m);

    @(posedge clk); #1;
    in_meta_valid       = 1'b1;
    in_meta_data.action = check ? ACTION_CHECK : ACTION_NOCHECK;
    for (int i = 0; i < nb; i++) drive_beat(tag, i, nb, empty);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 6'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_meta_ready && n < 400);
    if (!in_meta_ready) begin
      checks++;
      errors++;
      $display("FAIL meta_ready_timeout: got no in_meta_ready required one pulse");
    end
    @(posedge clk); #1;
    in_meta_valid = 1'b0;
  endtask

  int p0, o0, acc, hi;
`ifdef PDU_GEN_STATS_EN
  logic [31:0] s_tr, s_st;
`endif

  initial begin
    rst = 1'b1; in_meta_valid = 1'b0; in_meta_data.action = ACTION_NOCHECK;
    in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 6'd0; in_valid = 1'b0;
    el_valid = 1'b1; el_data = '0; mready = 1'b1; af = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({in_ready, in_meta_ready, el_ready, pdumeta_gen_valid, pdu_gen_valid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CHECK, 3 flits, empty 10, id 7
    el_data = 8'd7; p0 = pops;
    send_pkt(1'b1, 3, 6'd10, 8'd7, 16'h0001);
    chk("t1_size", 64'(last_meta.pdu_size), 64'd182);
    chk("t1_flits", 64'(last_meta.flits), 64'd3);
    chk("t1_id", 64'(last_meta.pdu_id), 64'd7);
    chk("t1_pops", 64'(pops - p0), 64'd1);

    // NOCHECK single flit (sop and eop on the same beat)
    el_data = 8'd3; p0 = pops;
    send_pkt(1'b0, 1, 6'd0, 8'd0, 16'h0002);
    chk("t2_size", 64'(last_meta.pdu_size), 64'd64);
    chk("t2_id", 64'(last_meta.pdu_id), 64'd0);
    chk("t2_pops", 64'(pops - p0), 64'd0);

    // 40-flit packet truncated at 31
    el_data = 8'd9; o0 = out_beats;
`ifdef PDU_GEN_STATS_EN
    s_tr = stat_trunc_cnt;
`endif
    send_pkt(1'b1, 40, 6'd20, 8'd9, 16'h0003);
    chk("t3_beats", 64'(out_beats - o0), 64'd31);
    chk("t3_size", 64'(last_meta.pdu_size), 64'd1984);
    chk("t3_flits", 64'(last_meta.flits), 64'd31);
`ifdef PDU_GEN_STATS_EN
    chk("t3_stat_trunc", 64'(stat_trunc_cnt - s_tr), 64'd1);
`endif

    // Exactly 31 flits with eop: not a truncation
    el_data = 8'd11; o0 = out_beats;
`ifdef PDU_GEN_STATS_EN
    s_tr = stat_trunc_cnt;
`endif
    send_pkt(1'b1, 31, 6'd5, 8'd11, 16'h0004);
    chk("t4_beats", 64'(out_beats - o0), 64'd31);
    chk("t4_size", 64'(last_meta.pdu_size), 64'd1979);
`ifdef PDU_GEN_STATS_EN
    chk("t4_stat_trunc", 64'(stat_trunc_cnt - s_tr), 64'd0);
`endif

    // Emptylist dry for 20 cycles
    el_valid = 1'b0; el_data = 8'd12; hi = 0;
`ifdef PDU_GEN_STATS_EN
    s_st = stat_id_stall_cnt;
`endif
    fork
      send_pkt(1'b1, 2, 6'd3, 8'd12, 16'h0005);
      begin
        acc = 0;
        do begin
          @(negedge clk);
          acc++;
        end while (!el_ready && acc < 50);
        if (in_ready) hi++;
        repeat (19) begin
          @(negedge clk);
          if (in_ready) hi++;
        end
        @(posedge clk); #1;
        el_valid = 1'b1;
      end
    join
    chk("t5_in_ready_during_stall", 64'(hi), 64'd0);
    chk("t5_id", 64'(last_meta.pdu_id), 64'd12);
`ifdef PDU_GEN_STATS_EN
    chk("t5_stat_stall", 64'(stat_id_stall_cnt - s_st), 64'd20);
`endif

    // almost_full in IDLE blocks the start
    af = 1'b1; el_data = 8'd20; p0 = pops;
    fork
      send_pkt(1'b1, 2, 6'd0, 8'd20, 16'h0006);
      begin
        acc = 0;
        repeat (12) begin
          @(negedge clk);
          if (in_ready || el_ready) acc++;
        end
        chk("t6_af_blocks", 64'(acc), 64'd0);
        @(posedge clk); #1;
        af = 1'b0;
      end
    join
    chk("t6_pops", 64'(pops - p0), 64'd1);

    // almost_full raised mid-PDU: PDU completes
    el_data = 8'd21; o0 = out_beats;
    fork
      send_pkt(1'b1, 6, 6'd1, 8'd21, 16'h0007);
      begin
        repeat (5) @(posedge clk);
        #1 af = 1'b1;
      end
    join
    af = 1'b0;
    chk("t7_beats", 64'(out_beats - o0), 64'd6);
    chk("t7_size", 64'(last_meta.pdu_size), 64'd383);

    // Random data backpressure plus held metadata ready
    bp_en = 1'b1; mready = 1'b0; el_data = 8'd30;
    fork
      send_pkt(1'b1, 8, 6'd63, 8'd30, 16'h0008);
      begin
        acc = 0;
        do begin
          @(negedge clk);
          acc++;
        end while (!pdumeta_gen_valid && acc < 400);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        mready = 1'b1;
      end
    join
    bp_en = 1'b0;
    chk("t8_size", 64'(last_meta.pdu_size), 64'd449);

    // Reset after 2 of 4 beats
    el_data = 8'd5;
    for (int i = 0; i < 2; i++) begin
      e_b.data = mk_data(16'h0009, i); e_b.sop = (i == 0); e_b.eop = 1'b0; e_b.empty = 6'd0;
      exp_beats.push_back(e_b);
    end
    @(posedge clk); #1;
    in_meta_valid = 1'b1; in_meta_data.action = ACTION_CHECK;
    drive_beat(16'h0009, 0, 4, 6'd0);
    drive_beat(16'h0009, 1, 4, 6'd0);
    rst = 1'b1; in_valid = 1'b0; in_meta_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t9_outputs_after_reset", 64'({in_ready, in_meta_ready, el_ready, pdumeta_gen_valid, pdu_gen_valid}), 64'd0);
    chk("t9_partial_beats_out", 64'(exp_beats.size()), 64'd0);
`ifdef PDU_GEN_STATS_EN
    chk("t9_stat_reset", 64'(stat_pdu_cnt), 64'd0);
`endif

    // Normal packet after reset
    el_data = 8'd6;
    send_pkt(1'b1, 4, 6'd8, 8'd6, 16'h000A);
    chk("t10_size", 64'(last_meta.pdu_size), 64'd248);
`ifdef PDU_GEN_STATS_EN
    chk("t10_stat_pdu", 64'(stat_pdu_cnt), 64'd1);
`endif

    repeat (3) @(posedge clk);
    chk("end_beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("end_meta_drained", 64'(exp_meta.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
